// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO SPART bridge: register offsets, STATUS/CTRL
// bit positions and the per-channel TX drain state encoding.
package mmio_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_OVF     = 5;
    localparam int ST_RX_CNT_LSB = 8;

    localparam int CTRL_OVF_CLR = 0;
    localparam int CTRL_IRQ_EN  = 1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_spart_bridge.sv
// Memory-mapped bridge from the CPU data port to NCH buffered SPART channels,
// with TX/RX FIFOs, sticky overflow flags and a per-channel RX interrupt.
module mmio_spart_bridge
    import mmio_pkg::*;
#(
    parameter int         NCH      = 2,
    parameter int         TX_DEPTH = 16,
    parameter int         RX_DEPTH = 16,
    parameter logic [3:0] REGION   = 4'hA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_we,
    input  logic              cpu_re,
    output logic              mmio_sel,
    output logic [31:0]       mmio_rdata,
    output logic [8*NCH-1:0]  spart_tx_data,
    output logic [NCH-1:0]    spart_trmt,
    input  logic [NCH-1:0]    spart_tx_full,
    input  logic [8*NCH-1:0]  spart_rx_data,
    input  logic [NCH-1:0]    spart_rx_valid,
    output logic [NCH-1:0]    irq
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [3:0]  ch;
    logic [1:0]  rsel;
    logic        wr;
    logic        rd;
    logic [31:0] rdata_next;

    logic [NCH-1:0] hit;
    logic [NCH-1:0] tx_push_req;
    logic [NCH-1:0] tx_push;
    logic [NCH-1:0] tx_pop;
    logic [NCH-1:0] tx_full;
    logic [NCH-1:0] tx_empty;
    logic [NCH-1:0] rx_pop;
    logic [NCH-1:0] rx_full;
    logic [NCH-1:0] rx_empty;
    logic [NCH-1:0] ctrl_wr;
    logic [NCH-1:0] ovf_clr;
    logic [NCH-1:0] tx_ovf_evt;
    logic [NCH-1:0] rx_ovf_evt;
    logic [NCH-1:0] tx_ovf;
    logic [NCH-1:0] rx_ovf;
    logic [NCH-1:0] irq_en;

    logic [7:0]       tx_head [NCH];
    logic [7:0]       rx_head [NCH];
    logic [RX_CW-1:0] rx_count [NCH];
    logic [TX_CW-1:0] tx_count_unused [NCH];
    logic             addr_unused;

    assign mmio_sel    = (cpu_addr[23:20] == REGION);
    assign ch          = cpu_addr[7:4];
    assign rsel        = cpu_addr[3:2];
    assign wr          = mmio_sel && (|cpu_we);
    assign rd          = mmio_sel && cpu_re;
    assign irq         = irq_en & ~rx_empty;
    assign addr_unused = ^{cpu_addr[31:24], cpu_addr[19:8], cpu_addr[1:0], cpu_wdata[31:8]};

    // Per-channel register decode; a channel number at or above NCH hits nothing.
    always_comb begin
        hit         = '0;
        tx_push_req = '0;
        tx_push     = '0;
        rx_pop      = '0;
        ctrl_wr     = '0;
        ovf_clr     = '0;
        tx_ovf_evt  = '0;
        rx_ovf_evt  = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c]         = (ch == 4'(c));
            tx_push_req[c] = wr && hit[c] && (rsel == REG_TXDATA);
            tx_push[c]     = tx_push_req[c] && !tx_full[c];
            rx_pop[c]      = rd && hit[c] && (rsel == REG_RXDATA) && !rx_empty[c];
            ctrl_wr[c]     = wr && hit[c] && (rsel == REG_CTRL);
            ovf_clr[c]     = ctrl_wr[c] && cpu_wdata[CTRL_OVF_CLR];
            tx_ovf_evt[c]  = tx_push_req[c] && tx_full[c];
            rx_ovf_evt[c]  = spart_rx_valid[c] && rx_full[c] && !rx_pop[c];
        end
    end

    // Read data is built from pre-edge state and registered for one-cycle latency.
    always_comb begin
        rdata_next = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd && hit[c]) begin
                case (rsel)
                    REG_STATUS: begin
                        rdata_next[ST_TX_FULL]             = tx_full[c];
                        rdata_next[ST_TX_EMPTY]            = tx_empty[c];
                        rdata_next[ST_RX_FULL]             = rx_full[c];
                        rdata_next[ST_RX_EMPTY]            = rx_empty[c];
                        rdata_next[ST_TX_OVF]              = tx_ovf[c];
                        rdata_next[ST_RX_OVF]              = rx_ovf[c];
                        rdata_next[ST_RX_CNT_LSB +: 8]     = 8'(rx_count[c]);
                    end
                    REG_RXDATA: begin
                        if (!rx_empty[c]) begin
                            rdata_next[7:0] = rx_head[c];
                        end
                    end
                    REG_CTRL: begin
                        rdata_next[CTRL_IRQ_EN] = irq_en[c];
                    end
                    default: begin
                        rdata_next = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_rdata <= '0;
            tx_ovf     <= '0;
            rx_ovf     <= '0;
            irq_en     <= '0;
        end else begin
            mmio_rdata <= rdata_next;
            for (int c = 0; c < NCH; c++) begin
                tx_ovf[c] <= tx_ovf_evt[c] || (tx_ovf[c] && !ovf_clr[c]);
                rx_ovf[c] <= rx_ovf_evt[c] || (rx_ovf[c] && !ovf_clr[c]);
                if (ctrl_wr[c]) begin
                    irq_en[c] <= cpu_wdata[CTRL_IRQ_EN];
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        tx_state_t  state;
        logic       trmt_r;
        logic [7:0] data_r;

        sync_fifo #(
            .WIDTH (8),
            .DEPTH (TX_DEPTH)
        ) u_tx_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (tx_push[c]),
            .din   (cpu_wdata[7:0]),
            .pop   (tx_pop[c]),
            .dout  (tx_head[c]),
            .full  (tx_full[c]),
            .empty (tx_empty[c]),
            .count (tx_count_unused[c])
        );

        sync_fifo #(
            .WIDTH (8),
            .DEPTH (RX_DEPTH)
        ) u_rx_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (spart_rx_valid[c]),
            .din   (spart_rx_data[8*c +: 8]),
            .pop   (rx_pop[c]),
            .dout  (rx_head[c]),
            .full  (rx_full[c]),
            .empty (rx_empty[c]),
            .count (rx_count[c])
        );

        // The head is popped on the IDLE->SEND edge so the strobe and byte are both registered.
        assign tx_pop[c] = (state == TX_IDLE) && !tx_empty[c] && !spart_tx_full[c];

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= TX_IDLE;
                trmt_r <= 1'b0;
                data_r <= '0;
            end else begin
                case (state)
                    TX_IDLE: begin
                        trmt_r <= 1'b0;
                        if (tx_pop[c]) begin
                            state  <= TX_SEND;
                            trmt_r <= 1'b1;
                            data_r <= tx_head[c];
                        end
                    end
                    TX_SEND: begin
                        state  <= TX_IDLE;
                        trmt_r <= 1'b0;
                    end
                    default: begin
                        state  <= TX_IDLE;
                        trmt_r <= 1'b0;
                    end
                endcase
            end
        end

        assign spart_trmt[c]           = trmt_r;
        assign spart_tx_data[8*c +: 8] = data_r;
    end

endmodule

// File: tb/tb_mmio_spart_bridge.sv
// Randomized bench for mmio_spart_bridge against a queue-based channel model,
// with directed sequences for the reset, TX, overflow and RX interrupt cases.
module tb_mmio_spart_bridge;

    localparam int NCH = 2;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic              clk;
    logic              rst;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_we;
    logic              cpu_re;
    logic              mmio_sel;
    logic [31:0]       mmio_rdata;
    logic [8*NCH-1:0]  spart_tx_data;
    logic [NCH-1:0]    spart_trmt;
    logic [NCH-1:0]    spart_tx_full;
    logic [8*NCH-1:0]  spart_rx_data;
    logic [NCH-1:0]    spart_rx_valid;
    logic [NCH-1:0]    irq;

    mmio_spart_bridge #(
        .NCH      (NCH),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD),
        .REGION   (4'hA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .mmio_sel       (mmio_sel),
        .mmio_rdata     (mmio_rdata),
        .spart_tx_data  (spart_tx_data),
        .spart_trmt     (spart_trmt),
        .spart_tx_full  (spart_tx_full),
        .spart_rx_data  (spart_rx_data),
        .spart_rx_valid (spart_rx_valid),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int cnt0  = 0;
    logic [7:0] obs1_data [$];
    int         obs1_cyc  [$];

    // Reference model: byte queues per channel plus flags.
    logic [7:0]     m_tx_q [NCH][$];
    logic [7:0]     m_rx_q [NCH][$];
    logic [NCH-1:0] m_tx_ovf, m_rx_ovf, m_irq_en, m_busy, m_trmt;
    logic [7:0]     m_txd [NCH];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input int ch, input int rg);
        logic [31:0] v;
        v = '0;
        if (ch < NCH) begin
            case (rg)
                1: begin
                    v[0]    = (m_tx_q[ch].size() == TXD);
                    v[1]    = (m_tx_q[ch].size() == 0);
                    v[2]    = (m_rx_q[ch].size() == RXD);
                    v[3]    = (m_rx_q[ch].size() == 0);
                    v[4]    = m_tx_ovf[ch];
                    v[5]    = m_rx_ovf[ch];
                    v[15:8] = 8'(m_rx_q[ch].size());
                end
                2: if (m_rx_q[ch].size() != 0) v[7:0] = m_rx_q[ch][0];
                3: v[1] = m_irq_en[ch];
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_tx_q[c].delete();
            m_rx_q[c].delete();
            m_txd[c] = 8'h00;
        end
        m_tx_ovf = '0; m_rx_ovf = '0; m_irq_en = '0; m_busy = '0; m_trmt = '0;
    endtask

    // One clock cycle: drive the CPU op, predict, step the edge, compare.
    task automatic apply_stimulus(input bit in_region, input int ch, input int rg,
                                  input bit wr, input bit rd, input logic [31:0] wdata);
        logic [31:0]      a;
        logic [31:0]      exp_rd;
        logic [8*NCH-1:0] exp_bus;
        logic [NCH-1:0]   exp_irq;
        bit hit, txpush, rxpop, clr, txo, rxo, send;
        a = $urandom;
        a[23:20] = in_region ? 4'hA : (4'hA ^ 4'($urandom_range(1, 15)));
        a[7:4]   = 4'(ch);
        a[3:2]   = 2'(rg);
        cpu_addr  = a;
        cpu_wdata = wdata;
        cpu_we    = wr ? 4'($urandom_range(1, 15)) : 4'h0;
        cpu_re    = rd;
        #1;
        check_output("mmio_sel", 32'(mmio_sel), 32'(in_region));
        exp_rd = (in_region && rd && !rst) ? model_read(ch, rg) : 32'h0;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                hit    = in_region && (ch == c);
                send   = !m_busy[c] && (m_tx_q[c].size() != 0) && !spart_tx_full[c];
                txpush = hit && wr && (rg == 0);
                rxpop  = hit && rd && (rg == 2) && (m_rx_q[c].size() != 0);
                clr    = hit && wr && (rg == 3) && wdata[0];
                txo    = txpush && (m_tx_q[c].size() == TXD);
                rxo    = spart_rx_valid[c] && (m_rx_q[c].size() == RXD) && !rxpop;
                if (send) m_txd[c] = m_tx_q[c].pop_front();
                m_trmt[c] = send;
                m_busy[c] = send;
                if (txpush && !txo) m_tx_q[c].push_back(wdata[7:0]);
                if (rxpop) void'(m_rx_q[c].pop_front());
                if (spart_rx_valid[c] && !rxo) m_rx_q[c].push_back(spart_rx_data[8*c +: 8]);
                m_tx_ovf[c] = txo || (m_tx_ovf[c] && !clr);
                m_rx_ovf[c] = rxo || (m_rx_ovf[c] && !clr);
                if (hit && wr && (rg == 3)) m_irq_en[c] = wdata[1];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            exp_bus[8*c +: 8] = m_txd[c];
            exp_irq[c]        = m_irq_en[c] && (m_rx_q[c].size() != 0);
        end
        check_output("rdata", mmio_rdata, exp_rd);
        check_output("trmt", 32'(spart_trmt), 32'(m_trmt));
        check_output("tx_data", 32'(spart_tx_data), 32'(exp_bus));
        check_output("irq", 32'(irq), 32'(exp_irq));
        if (spart_trmt[0]) cnt0++;
        if (spart_trmt[1]) begin
            obs1_data.push_back(spart_tx_data[15:8]);
            obs1_cyc.push_back(cyc);
        end
        @(negedge clk);
        spart_rx_valid = '0;
    endtask

    task automatic cpu_write(input int ch, input int rg, input logic [31:0] d);
        apply_stimulus(1'b1, ch, rg, 1'b1, 1'b0, d);
    endtask

    task automatic cpu_read(input int ch, input int rg);
        apply_stimulus(1'b1, ch, rg, 1'b0, 1'b1, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1, $urandom_range(0, 15), $urandom_range(0, 3), 1'b0, 1'b0, $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = '0; cpu_re = 1'b0;
        spart_tx_full = '0; spart_rx_data = '0; spart_rx_valid = '0;
        model_reset();
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst_irq", 32'(irq), 32'h0);
        check_output("rst_trmt", 32'(spart_trmt), 32'h0);
        cpu_read(0, 1);
        check_output("rst_status", mmio_rdata, 32'h0000_000A);

        $display("[TB] ch1 transmit sequence");
        obs1_data.delete(); obs1_cyc.delete(); cnt0 = 0;
        cpu_write(1, 0, 32'h41);
        cpu_write(1, 0, 32'h42);
        cpu_write(1, 0, 32'h43);
        idle(8);
        check_output("ch1_count", 32'(obs1_data.size()), 32'd3);
        check_output("ch0_quiet", 32'(cnt0), 32'd0);
        if (obs1_data.size() == 3) begin
            check_output("ch1_b0", 32'(obs1_data[0]), 32'h41);
            check_output("ch1_b1", 32'(obs1_data[1]), 32'h42);
            check_output("ch1_b2", 32'(obs1_data[2]), 32'h43);
            check_output("ch1_gap0", 32'(obs1_cyc[1] - obs1_cyc[0]), 32'd2);
            check_output("ch1_gap1", 32'(obs1_cyc[2] - obs1_cyc[1]), 32'd2);
        end

        $display("[TB] ch0 tx overflow");
        spart_tx_full = 2'b01;
        for (int i = 0; i < 17; i++) cpu_write(0, 0, $urandom);
        cpu_read(0, 1);
        check_output("txovf_status", mmio_rdata, 32'h0000_0019);
        cnt0 = 0;
        spart_tx_full = 2'b00;
        idle(40);
        check_output("txovf_sent", 32'(cnt0), 32'd16);
        cpu_write(0, 3, 32'h1);
        cpu_read(0, 1);
        check_output("txovf_clear", mmio_rdata, 32'h0000_000A);

        $display("[TB] rx interrupt");
        cpu_write(0, 3, 32'h2);
        spart_rx_data = 16'h005A;
        spart_rx_valid = 2'b01;
        idle(1);
        check_output("irq_set", 32'(irq[0]), 32'h1);
        cpu_read(0, 2);
        check_output("rx_5a", mmio_rdata, 32'h0000_005A);
        check_output("irq_clr", 32'(irq[0]), 32'h0);
        cpu_read(0, 2);
        check_output("rx_empty_rd", mmio_rdata, 32'h0);

        $display("[TB] rx full boundary");
        for (int i = 0; i < RXD; i++) begin
            spart_rx_data = 16'($urandom);
            spart_rx_valid = 2'b01;
            idle(1);
        end
        spart_rx_data = 16'($urandom);
        spart_rx_valid = 2'b01;
        cpu_read(0, 2);
        cpu_read(0, 1);
        check_output("rxfull_pushpop", mmio_rdata, 32'h0000_1006);
        spart_rx_valid = 2'b01;
        idle(1);
        cpu_read(0, 1);
        check_output("rxfull_ovf", mmio_rdata, 32'h0000_1026);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            int op;
            for (int c = 0; c < NCH; c++) begin
                spart_tx_full[c]  = ($urandom_range(0, 3) == 0);
                spart_rx_valid[c] = ($urandom_range(0, 3) == 0);
            end
            spart_rx_data = 16'($urandom);
            op = $urandom_range(0, 9);
            apply_stimulus($urandom_range(0, 15) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                           op < 4, (op >= 4) && (op < 8), $urandom);
        end

        $display("[TB] reset mid-transfer");
        spart_tx_full = 2'b00;
        idle(40);
        spart_tx_full = 2'b10;
        for (int i = 0; i < 4; i++) cpu_write(1, 0, $urandom);
        spart_tx_full = 2'b00;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_output("rst_mid_trmt", 32'(spart_trmt), 32'h0);
        obs1_data.delete(); obs1_cyc.delete();
        idle(10);
        check_output("rst_mid_strobes", 32'(obs1_data.size()), 32'd0);
        cpu_read(1, 1);
        check_output("rst_mid_status", mmio_rdata, 32'h0000_000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_spart_bridge.md
# mmio_spart_bridge

Parametrised memory-mapped I/O bridge between the CPU data port and NCH SPART channels, with per-channel TX/RX FIFOs, sticky overflow flags and per-channel RX interrupt. Decodes the MMIO region, replaces single-register, unbuffered SPART access with buffered multi-channel access, and returns read data with one-cycle latency to match block-RAM reads in the memory path.

## Interface
- NCH, 2: number of SPART channels, 1..16.
- TX_DEPTH, 16: TX FIFO entries per channel, power of 2, ≥2.
- RX_DEPTH, 16: RX FIFO entries per channel, power of 2, ≥2.
- REGION, 4'hA: value of cpu_addr[23:20] selecting this block.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data; bits [7:0] used for TXDATA, [1:0] for CTRL.
- cpu_we  in  4  byte write enables; any bit set = write.
- cpu_re  in  1  CPU read strobe.
- mmio_sel  out  1  combinational: cpu_addr[23:20]==REGION.
- mmio_rdata  out  32  registered read data.
- spart_tx_data  out  8*NCH  TX byte, channel c at [8c+7:8c].
- spart_trmt  out  NCH  one-cycle transmit strobe per channel.
- spart_tx_full  in  NCH  SPART TX busy/full.
- spart_rx_data  in  8*NCH  received byte per channel.
- spart_rx_valid  in  NCH  one-cycle strobe: spart_rx_data valid.
- irq  out  NCH  level: rx_irq_en[c] & RX FIFO c non-empty.

## Operation
- Address map (when mmio_sel): channel = cpu_addr[7:4]; register = cpu_addr[3:2]; cpu_addr[1:0] ignored. Channel ≥ NCH: writes ignored, reads return 0.
- Reg 0x0 TXDATA: write pushes cpu_wdata[7:0] to TX FIFO; read returns 0.
- Reg 0x4 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf, bit5 rx_ovf, bits[15:8] rx count (zero-extended), rest 0.
- Reg 0x8 RXDATA: read returns {24'h0, head byte} and pops; read when empty returns 0, no pop.
- Reg 0xC CTRL: read {30'h0, rx_irq_en, 1'b0}; write: bit1 → rx_irq_en, bit0=1 clears tx_ovf and rx_ovf.
- TX push when full: data dropped, tx_ovf set. RX push (spart_rx_valid) when full and no simultaneous pop: byte dropped, rx_ovf set. Push with simultaneous pop on full FIFO: accepted, count unchanged.
- TX drain per channel, 2-state FSM IDLE/SEND: IDLE→SEND when TX FIFO non-empty and spart_tx_full low; in SEND spart_trmt=1, spart_tx_data=popped byte, head popped; SEND→IDLE unconditionally. Guarantees ≥1 idle cycle between strobes.
- Overflow clear and a new overflow in the same cycle: flag remains set.
- No write/read when !mmio_sel or cpu_re/cpu_we inactive; mmio_rdata=0 cycles with no selected read.

## Timing
- Reset: all FIFOs empty, ovf flags 0, rx_irq_en 0, FSMs IDLE, mmio_rdata 0, spart_trmt 0, spart_tx_data 0, irq 0.
- Read latency 1: cpu_re at edge k → mmio_rdata valid after edge k, for one cycle; RX pop effective at edge k.
- TX: write at edge k → earliest spart_trmt high after edge k+1; max rate 1 byte per 2 cycles per channel.
- RX: spart_rx_valid at edge k → rx_empty clear and irq (if enabled) after edge k; readable in the next cycle.
- STATUS reflects state before the current edge's updates.
- Reset mid-transfer: FIFO contents discarded, pending strobe cancelled, next cycle all outputs at reset values.

## Structure
- Package mmio_pkg: register offsets (TXDATA/STATUS/RXDATA/CTRL), STATUS/CTRL bit positions, TX FSM state enum.
- Sub-module sync_fifo (params WIDTH, DEPTH): push/pop/full/empty/count, push-on-full-with-pop accepted; instantiated 2×NCH via generate.

## Test plan
- Reset, then read STATUS ch0 → 32'h0000_000A (tx_empty, rx_empty); irq=0, spart_trmt=0.
- Write 0x41, 0x42, 0x43 to ch1 TXDATA, spart_tx_full=0 → three spart_trmt[1] pulses two cycles apart, data 41,42,43; ch0 idle.
- Hold spart_tx_full[0]=1, write 17 bytes to ch0 (TX_DEPTH=16) → STATUS bit0 and bit4 set; release → exactly 16 bytes sent; CTRL write 1 clears tx_ovf.
- Set CTRL rx_irq_en on ch0, pulse spart_rx_valid with 0x5A → irq[0]=1; RXDATA read → 32'h5A next cycle, irq[0]=0, second read → 0.
- Fill ch0 RX to 16, then same-cycle spart_rx_valid and RXDATA read → count stays 16, rx_ovf 0; extra push alone → rx_ovf 1.
- Assert rst with ch1 TX FIFO holding 4 bytes → no further strobes, STATUS ch1 → 32'h0000_000A.
